// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register of the 5-stage MIPS core.
// Captures the decoded instruction and presents it to EX. It also detects
// load-use hazards against the held instruction, stalls IF/ID and inserts
// bubbles. Branch/jump flush and a global hold are handled here as well.
//
// Optional feature: define ID_WB_BYPASS_EN to bypass WB write data into the
// captured Rs/Rt values. Without it, the wb_* ports are ignored.
//
// Ports:
//   clk, rst_n               clock, async active-low reset
//   hold_i, flush_i          global freeze; branch/jump flush
//   id_*                     decoded instruction fields from ID
//   wb_rd_i/regwr_i/val_i    WB write port (bypass feature only)
//   ex_*                     registered instruction fields toward EX
//   stall_o                  combinational stall for PC and IF/ID
//   bubble_cnt_o             wrapping count of inserted bubbles
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic [4:0]        id_rd_i,
    input  logic              id_uses_rt_i,
    input  logic [DATA_W-1:0] id_rsval_i,
    input  logic [DATA_W-1:0] id_rtval_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [CTRL_W-1:0] id_ctrl_i,
    input  logic              id_regwr_i,
    input  logic              id_memrd_i,
    input  logic              id_memwr_i,
    input  logic              id_memtoreg_i,
    input  logic              id_alusrc_i,
    input  logic [4:0]        wb_rd_i,
    input  logic              wb_regwr_i,
    input  logic [DATA_W-1:0] wb_val_i,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic [DATA_W-1:0] ex_rsval_o,
    output logic [DATA_W-1:0] ex_rtval_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [CTRL_W-1:0] ex_ctrl_o,
    output logic              ex_regwr_o,
    output logic              ex_memrd_o,
    output logic              ex_memwr_o,
    output logic              ex_memtoreg_o,
    output logic              ex_alusrc_o,
    output logic              stall_o,
    output logic [31:0]       bubble_cnt_o
);

    localparam int unsigned CNT_W = 32;

    typedef struct packed {
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [DATA_W-1:0] rsval;
        logic [DATA_W-1:0] rtval;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc4;
        logic [CTRL_W-1:0] ctrl;
        logic              regwr;
        logic              memrd;
        logic              memwr;
        logic              memtoreg;
        logic              alusrc;
    } stage_t;

    stage_t            stage_q, stage_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic              luh_c;
    logic [DATA_W-1:0] rsval_c, rtval_c;

    // Load-use hazard against the instruction currently held for EX
    assign luh_c = stage_q.memrd && (stage_q.rd != 5'd0) &&
                   ((stage_q.rd == id_rs_i) ||
                    (id_uses_rt_i && (stage_q.rd == id_rt_i)));

    // A flush discards the ID instruction and a hold freezes everything,
    // so neither needs IF/ID held back.
    assign stall_o = luh_c && !flush_i && !hold_i;

`ifdef ID_WB_BYPASS_EN
    // Register file does not write through, so forward the WB write here
    always_comb begin
        rsval_c = id_rsval_i;
        rtval_c = id_rtval_i;
        if (wb_regwr_i && (wb_rd_i != 5'd0) && (wb_rd_i == id_rs_i)) rsval_c = wb_val_i;
        if (wb_regwr_i && (wb_rd_i != 5'd0) && (wb_rd_i == id_rt_i)) rtval_c = wb_val_i;
    end
`else
    logic wb_unused;
    assign wb_unused = ^{wb_rd_i, wb_regwr_i, wb_val_i};
    assign rsval_c = id_rsval_i;
    assign rtval_c = id_rtval_i;
`endif

    // Next-state: hold > flush > load-use bubble > capture
    always_comb begin
        stage_d      = stage_q;
        bubble_cnt_d = bubble_cnt_q;
        if (hold_i) begin
            stage_d = stage_q;
        end else if (flush_i || luh_c) begin
            stage_d      = '0;
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else begin
            stage_d.rs       = id_rs_i;
            stage_d.rt       = id_rt_i;
            stage_d.rd       = id_rd_i;
            stage_d.rsval    = rsval_c;
            stage_d.rtval    = rtval_c;
            stage_d.imm      = id_imm_i;
            stage_d.pc4      = id_pc4_i;
            stage_d.ctrl     = id_ctrl_i;
            stage_d.regwr    = id_regwr_i;
            stage_d.memrd    = id_memrd_i;
            stage_d.memwr    = id_memwr_i;
            stage_d.memtoreg = id_memtoreg_i;
            stage_d.alusrc   = id_alusrc_i;
        end
    end

    // State register; reset value is a NOP bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q      <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stage_q      <= stage_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_rs_o       = stage_q.rs;
    assign ex_rt_o       = stage_q.rt;
    assign ex_rd_o       = stage_q.rd;
    assign ex_rsval_o    = stage_q.rsval;
    assign ex_rtval_o    = stage_q.rtval;
    assign ex_imm_o      = stage_q.imm;
    assign ex_pc4_o      = stage_q.pc4;
    assign ex_ctrl_o     = stage_q.ctrl;
    assign ex_regwr_o    = stage_q.regwr;
    assign ex_memrd_o    = stage_q.memrd;
    assign ex_memwr_o    = stage_q.memwr;
    assign ex_memtoreg_o = stage_q.memtoreg;
    assign ex_alusrc_o   = stage_q.alusrc;
    assign bubble_cnt_o  = bubble_cnt_q;

endmodule
